ad_target: RTL
==============

Name: ad_target

Overview:
- Responder end of the 8-bit address/data bridge port; it sits on the far side of the bridge egress initiator.
- Each transfer is two beats: an address beat, then a data beat.
- Address byte: bit 7 = read(1)/write(0); bits 6:0 = register address.
- Serves a local register file: writes update it, reads return its contents on the read-data bus. A local-side read port and a write-notify strobe expose it to the rest of the chip.

Parameters:
- DEPTH, 16: number of 8-bit registers; legal range 1..128.
- WAIT_CYCLES, 0: wait states inserted between the address beat and the data beat; range 0..15.
- AW, clog2(DEPTH) (localparam, min 1): register index width.

Ports:
clk  in  1  clock; all logic on rising edge
rstN  in  1  reset, asynchronous, active-low
tg_valid  in  1  initiator has a beat on tg_ad
tg_ad  in  8  address byte (addr beat) or write data (data beat)
tg_ready  out  1  target accepts beat this cycle; a beat completes on tg_valid && tg_ready
tg_rdata  out  8  read data, stable from the cycle after the address beat through the data-beat cycle
wr_strobe  out  1  one-cycle pulse: a register was written
wr_addr  out  7  address of the written register (valid with wr_strobe)
wr_data  out  8  data written (valid with wr_strobe)
err_pulse  out  1  one-cycle pulse: a transfer completed to an out-of-range address
lcl_addr  in  AW  local read index
lcl_rdata  out  8  combinational read of regfile[lcl_addr]

Behaviour:
- Reset (async, rstN low):
  - state=T_IDLE; all registers = 8'h00.
  - tg_rdata=0, wr_strobe=0, wr_addr=0, wr_data=0, err_pulse=0, wait counter=0.
  - tg_ready=1 immediately.
  - Reset mid-transfer abandons the transfer; no partial write occurs.
- T_IDLE (tg_ready=1): on tg_valid, capture rw=tg_ad[7] and addr=tg_ad[6:0].
  - If rw=1 and addr<DEPTH: tg_rdata <= regfile[addr]. If rw=1 and addr>=DEPTH: tg_rdata <= 8'h00.
  - Next state: T_WAIT, loading the counter with WAIT_CYCLES; if WAIT_CYCLES=0, go straight to T_DATA.
- T_WAIT (tg_ready=0): decrement the counter every cycle regardless of tg_valid; go to T_DATA on the cycle the counter reaches 1.
- T_DATA (tg_ready=1): when tg_valid, the data beat completes and the next state is T_IDLE.
  - Write, in range: regfile[addr] <= tg_ad. Next cycle: wr_strobe=1, wr_addr=addr, wr_data=tg_ad.
  - Write, out of range: no register change, no wr_strobe; err_pulse=1 next cycle.
  - Read: no register change; err_pulse=1 next cycle if out of range. tg_rdata holds until the next read address beat; it is not cleared.
- tg_valid low in T_IDLE or T_DATA: hold state. A transfer is never aborted by the initiator, only by reset.
- Back-to-back transfers: the cycle after the data beat is T_IDLE with tg_ready=1, so a new address beat is accepted without a bubble.
- Read data is a snapshot taken at the address beat; a local-side change cannot occur because only the bus writes.
- Minimum latency:
  - Write with WAIT_CYCLES=0: address beat at cycle N, data beat at N+1, register and wr_strobe visible at N+2.
  - Read: tg_rdata valid at N+1.
- lcl_rdata is purely combinational. A same-cycle bus write to the same index shows the old value until the clock edge.
- lcl_addr>=DEPTH returns 8'h00.
- wr_strobe and err_pulse are mutually exclusive and never asserted for two consecutive cycles.

Decomposition:
- Shared package/include:
  - State encodings T_IDLE=2'b00, T_WAIT=2'b01, T_DATA=2'b10.
  - RW bit position constant (7).
  - Address field width constant (7).
- Sub-module tgt_regfile: DEPTH x 8 flops with async reset to 0. It has one synchronous write port and two combinational read ports, one for bus read capture and one for lcl_rdata.
- The FSM, wait counter and strobes stay in ad_target.

Test Plan:
- Reset then write: address beat 8'h05, data beat 8'hA5 (WAIT_CYCLES=0) -> wr_strobe=1 with wr_addr=5, wr_data=8'hA5 two cycles after the address beat; lcl_addr=5 gives lcl_rdata=8'hA5.
- Read back: address beat 8'h85 -> tg_rdata=8'hA5 the next cycle, held through the data beat; no wr_strobe.
- Out of range (DEPTH=16): write 8'h14/8'h3C -> err_pulse once, no wr_strobe, all registers unchanged. Read 8'h94 -> tg_rdata=8'h00 and err_pulse.
- Wait states (WAIT_CYCLES=3): address beat at cycle N -> tg_ready=0 for N+1..N+3 and 1 at N+4; tg_valid held high throughout completes the data beat at N+4.
- Back-to-back plus stall: write 8'h01/8'h11, then immediately read 8'h81 with tg_valid low for 2 cycles in T_DATA -> state holds and tg_rdata=8'h11 is stable; the transfer completes when tg_valid returns.
- Reset mid-transfer: after address beat 8'h02, assert rstN low for 1 cycle before the data beat -> register 2 stays 8'h00 and there is no strobe; tg_ready=1 after reset and a new address beat is accepted.

Source files
------------

// File: rtl/ad_target_pkg.sv
// Shared definitions for the address/data bridge target.
package ad_target_pkg;

  typedef enum logic [1:0] {
    T_IDLE = 2'b00,
    T_WAIT = 2'b01,
    T_DATA = 2'b10
  } tgt_state_e;

  // Bit 7 of the address byte selects read (1) or write (0).
  localparam int unsigned RW_BIT = 7;
  localparam int unsigned ADDR_W = 7;

  // Register index width; a single-entry file still needs one index bit.
  function automatic int unsigned idx_width(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ad_target_if.sv
// Two-beat address/data bus between the bridge initiator and the target.
interface ad_target_if;
  logic       tg_valid;
  logic [7:0] tg_ad;
  logic       tg_ready;
  logic [7:0] tg_rdata;

  modport master (
    output tg_valid,
    output tg_ad,
    input  tg_ready,
    input  tg_rdata
  );

  modport slave (
    input  tg_valid,
    input  tg_ad,
    output tg_ready,
    output tg_rdata
  );
endinterface

// File: rtl/tgt_regfile.sv
// DEPTH x 8 register file: one synchronous write port, two combinational read ports.
module tgt_regfile #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [7:0]    rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [7:0]    rdata_b
);

  logic [7:0] mem_q [DEPTH];

  // Storage: cleared on reset, written only by the bus data beat.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Indices past the last register (non-power-of-two DEPTH) read as zero.
  assign rdata_a = (32'(raddr_a) < DEPTH) ? mem_q[raddr_a] : 8'h00;
  assign rdata_b = (32'(raddr_b) < DEPTH) ? mem_q[raddr_b] : 8'h00;

endmodule

// File: rtl/ad_target.sv
// Responder end of the 8-bit address/data bridge port, serving a local register file.
module ad_target
  import ad_target_pkg::*;
#(
  parameter int unsigned  DEPTH       = 16,
  parameter int unsigned  WAIT_CYCLES = 0,
  localparam int unsigned AW          = idx_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rstN,
  ad_target_if.slave        bus,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              err_pulse,
  input  logic [AW-1:0]     lcl_addr,
  output logic [7:0]        lcl_rdata
);

  tgt_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] beat_addr;
  logic              beat_in_range;
  logic              cur_in_range;
  logic              rf_we;
  logic [7:0]        rf_bus_rdata;

  assign beat_addr     = bus.tg_ad[ADDR_W-1:0];
  assign beat_in_range = 32'(beat_addr) < DEPTH;
  assign cur_in_range  = 32'(addr_q) < DEPTH;

  tgt_regfile #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regfile (
    .clk     (clk),
    .rstN    (rstN),
    .we      (rf_we),
    .waddr   (addr_q[AW-1:0]),
    .wdata   (bus.tg_ad),
    .raddr_a (beat_addr[AW-1:0]),
    .rdata_a (rf_bus_rdata),
    .raddr_b (lcl_addr),
    .rdata_b (lcl_rdata)
  );

  // Transfer sequencing, read-data snapshot and write/error pulse generation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    rdata_d     = rdata_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    err_d       = 1'b0;
    rf_we       = 1'b0;

    unique case (state_q)
      T_IDLE: begin
        if (bus.tg_valid) begin
          rw_d   = bus.tg_ad[RW_BIT];
          addr_d = beat_addr;
          // Read data is snapshotted at the address beat; write beats leave it alone.
          if (bus.tg_ad[RW_BIT]) begin
            rdata_d = beat_in_range ? rf_bus_rdata : 8'h00;
          end
          if (WAIT_CYCLES == 0) begin
            state_d = T_DATA;
          end else begin
            state_d = T_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      T_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = T_DATA;
        end
      end
      T_DATA: begin
        if (bus.tg_valid) begin
          state_d = T_IDLE;
          if (!cur_in_range) begin
            err_d = 1'b1;
          end else if (!rw_q) begin
            rf_we       = 1'b1;
            wr_strobe_d = 1'b1;
            wr_addr_d   = addr_q;
            wr_data_d   = bus.tg_ad;
          end
        end
      end
      default: begin
        state_d = T_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= T_IDLE;
      cnt_q       <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      rdata_q     <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      rdata_q     <= rdata_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      err_q       <= err_d;
    end
  end

  assign bus.tg_ready = (state_q != T_WAIT);
  assign bus.tg_rdata = rdata_q;
  assign wr_strobe    = wr_strobe_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign err_pulse    = err_q;

endmodule
